img_stream_loader: RTL

IMG_STREAM_LOADER -- requirements
Module: img_stream_loader

---
 rtl/img_stream_loader.sv | 71 +++++++
 1 files changed

// File: rtl/img_stream_loader.sv
// img_stream_loader: assembles IC binary channel images of IMG_SIZE x IMG_SIZE pixels from a BUS_W-bit beat stream
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   in_valid/in_data    beat offered, pixel bits with LSB = lowest pixel index
//   in_ready            high while loading (LOAD state)
//   abort               synchronous discard of the frame in progress, clears the images
//   consume_done        downstream releases a full frame
//   img_out[c]          channel c image, pixel index = row*IMG_SIZE+col
//   data_out_ready      high while a complete frame is held (FULL state)
module img_stream_loader #(
  parameter int IMG_SIZE = 28,
  parameter int IC       = 10,
  parameter int BUS_W    = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic [BUS_W-1:0]             in_data,
  output logic                         in_ready,
  input  logic                         abort,
  input  logic                         consume_done,
  output logic [IMG_SIZE*IMG_SIZE-1:0] img_out [0:IC-1],
  output logic                         data_out_ready
);
  localparam int N = IMG_SIZE * IMG_SIZE;
  localparam int BEATS = (N + BUS_W - 1) / BUS_W;
  localparam int BW = BEATS > 1 ? $clog2(BEATS) : 1;
  localparam int CW = IC > 1 ? $clog2(IC) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
  localparam logic [CW-1:0] LAST_CH = CW'(IC - 1);
  typedef enum logic {LOAD, FULL} state_t;
  state_t          state_q;
  logic [BW-1:0]   beat_q;
  logic [CW-1:0]   ch_q;
  logic [N-1:0]    img_q [0:IC-1];
  // Each image bit is written only when its own beat/channel slot is active,
  // so bits of the last beat that fall beyond N simply have no destination.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= LOAD;
      beat_q  <= '0;
      ch_q    <= '0;
      for (int c = 0; c < IC; c++) img_q[c] <= '0;
    end else if (abort) begin
      state_q <= LOAD;
      beat_q  <= '0;
      ch_q    <= '0;
      for (int c = 0; c < IC; c++) img_q[c] <= '0;
    end else if (state_q == FULL) begin
      if (consume_done) begin
        state_q <= LOAD;
        beat_q  <= '0;
        ch_q    <= '0;
      end
    end else if (in_valid) begin
      for (int c = 0; c < IC; c++)
        for (int i = 0; i < N; i++)
          if (ch_q == CW'(c) && beat_q == BW'(i / BUS_W)) img_q[c][i] <= in_data[i % BUS_W];
      if (beat_q == LAST_BEAT) begin
        beat_q <= '0;
        ch_q   <= ch_q == LAST_CH ? '0 : ch_q + CW'(1);
        if (ch_q == LAST_CH) state_q <= FULL;
      end else begin
        beat_q <= beat_q + BW'(1);
      end
    end
  end
  assign in_ready       = state_q == LOAD;
  assign data_out_ready = state_q == FULL;
  assign img_out        = img_q;
endmodule
